// File: rtl/calc_pkg.sv
// calc_pkg: state and opcode definitions shared by the loader and the calculator core.
package calc_pkg;

    localparam int OPCW = 2;

    localparam logic [OPCW-1:0] OP_ADD = 2'd0;
    localparam logic [OPCW-1:0] OP_SUB = 2'd1;
    localparam logic [OPCW-1:0] OP_MUL = 2'd2;
    localparam logic [OPCW-1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        FIRE,
        WAIT
    } loader_state_t;

endpackage

// File: rtl/nibble_shifter.sv
// nibble_shifter: OPW-bit register that shifts NIB bits in at the LSB end, most significant nibble first.
module nibble_shifter #(
    parameter int OPW = 8,
    parameter int NIB = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           load,
    input  logic [NIB-1:0] din,
    output logic [OPW-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clear)
            q <= '0;
        else if (load)
            q <= (q << NIB) | OPW'(din);
    end

endmodule

// File: rtl/input_loader.sv
// input_loader: deserialises opcode and two operands from a nibble pad bus,
// launches the calculator with a one-cycle start and holds off until done_calc.
module input_loader
    import calc_pkg::*;
#(
    parameter int OPW  = 8,
    parameter int NIB  = 4,
    parameter int OPCW = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NIB-1:0]  data_in,
    input  logic            data_valid,
    input  logic            abort,
    input  logic            done_calc,
    output logic [OPCW-1:0] op,
    output logic [OPW-1:0]  a,
    output logic [OPW-1:0]  b,
    output logic            start,
    output logic            busy,
    output logic            overrun
);

    localparam int NN = OPW / NIB;
    localparam int CW = (NN > 1) ? $clog2(NN) : 1;

    loader_state_t state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last;

    // abort outranks any nibble, so the shifters must not move on an abort cycle
    assign accept = data_valid && !abort;
    assign last   = cnt == CW'(NN - 1);
    assign busy   = (state == FIRE) || (state == WAIT);

    nibble_shifter #(.OPW(OPW), .NIB(NIB)) u_a (
        .clock (clock),
        .reset (reset),
        .clear (accept && state == IDLE),
        .load  (accept && state == LOAD_A),
        .din   (data_in),
        .q     (a)
    );

    nibble_shifter #(.OPW(OPW), .NIB(NIB)) u_b (
        .clock (clock),
        .reset (reset),
        .clear (accept && state == IDLE),
        .load  (accept && state == LOAD_B),
        .din   (data_in),
        .q     (b)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= '0;
            start   <= 1'b0;
            overrun <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            cnt     <= '0;
            start   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: if (data_valid) begin
                    op      <= data_in[OPCW-1:0];
                    overrun <= 1'b0;
                    cnt     <= '0;
                    state   <= LOAD_A;
                end
                LOAD_A: if (data_valid) begin
                    cnt   <= last ? '0 : cnt + CW'(1);
                    state <= last ? LOAD_B : LOAD_A;
                end
                LOAD_B: if (data_valid) begin
                    cnt   <= last ? '0 : cnt + CW'(1);
                    state <= last ? FIRE : LOAD_B;
                    start <= last;
                end
                FIRE: begin
                    start   <= 1'b0;
                    state   <= WAIT;
                    overrun <= overrun | data_valid;
                end
                WAIT: begin
                    overrun <= overrun | data_valid;
                    state   <= done_calc ? IDLE : WAIT;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_loader.sv
// tb_input_loader: directed and random stimulus checked against a transaction-level model every cycle.
module tb_input_loader;

    localparam int NN = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       abort = 1'b0;
    logic       done_calc = 1'b0;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       start;
    logic       busy;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;

    input_loader dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .abort      (abort),
        .done_calc  (done_calc),
        .op         (op),
        .a          (a),
        .b          (b),
        .start      (start),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    // n counts nibbles taken in the current transaction; busy covers the start cycle and the wait for done_calc
    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       start;
        logic       busy;
        logic       ovr;
        int         n;
    } model_t;

    model_t m;

    function automatic model_t nxt(model_t c, logic dv, logic [3:0] d, logic ab, logic dc);
        model_t r = c;
        if (ab) begin
            r.n = 0;
            r.busy = 1'b0;
            r.start = 1'b0;
            r.ovr = 1'b0;
            return r;
        end
        r.start = 1'b0;
        if (c.busy) begin
            if (dv) r.ovr = 1'b1;
            if (dc && !c.start) r.busy = 1'b0;
        end else if (dv) begin
            if (c.n == 0) begin
                r.op = d[1:0];
                r.a = '0;
                r.b = '0;
                r.ovr = 1'b0;
            end else if (c.n <= NN)
                r.a = 8'((c.a << 4) | 8'(d));
            else
                r.b = 8'((c.b << 4) | 8'(d));
            r.n = c.n + 1;
            if (r.n == 2 * NN + 1) begin
                r.n = 0;
                r.start = 1'b1;
                r.busy = 1'b1;
            end
        end
        return r;
    endfunction

    always @(posedge clock or posedge reset)
        if (reset)
            m <= '0;
        else
            m <= nxt(m, data_valid, data_in, abort, done_calc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock)
        if (!reset) begin
            if (start) start_cnt++;
            chk("op", 32'(op), 32'(m.op));
            chk("a", 32'(a), 32'(m.a));
            chk("b", 32'(b), 32'(m.b));
            chk("start", 32'(start), 32'(m.start));
            chk("busy", 32'(busy), 32'(m.busy));
            chk("overrun", 32'(overrun), 32'(m.ovr));
        end

    task automatic cyc(input logic dv, input logic [3:0] d, input logic ab, input logic dc);
        data_valid = dv;
        data_in = d;
        abort = ab;
        done_calc = dc;
        @(posedge clock);
        #1;
        data_valid = 1'b0;
        abort = 1'b0;
        done_calc = 1'b0;
    endtask

    task automatic nib(input logic [3:0] d, input int gap);
        cyc(1'b1, d, 1'b0, 1'b0);
        repeat (gap) cyc(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    int s0;

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_op", 32'(op), 0);
        chk("rst_a", 32'(a), 0);
        chk("rst_b", 32'(b), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovr", 32'(overrun), 0);
        reset = 1'b0;
        cyc(1'b0, 4'h0, 1'b0, 1'b0);

        // back-to-back nibbles
        s0 = start_cnt;
        nib(4'h2, 0); nib(4'hA, 0); nib(4'h5, 0); nib(4'h3, 0); nib(4'hC, 0);
        chk("seq_start", 32'(start), 1);
        chk("seq_op", 32'(op), 2);
        chk("seq_a", 32'(a), 32'hA5);
        chk("seq_b", 32'(b), 32'h3C);
        chk("seq_busy", 32'(busy), 1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("seq_start_off", 32'(start), 0);
        chk("seq_pulses", 32'(start_cnt - s0), 1);

        // nibble during WAIT is dropped and flags overrun
        cyc(1'b1, 4'h7, 1'b0, 1'b0);
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_a", 32'(a), 32'hA5);
        chk("ovr_b", 32'(b), 32'h3C);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("done_busy", 32'(busy), 0);
        nib(4'h1, 0);
        chk("ovr_clr", 32'(overrun), 0);
        chk("new_op", 32'(op), 1);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);

        // gapped nibbles
        s0 = start_cnt;
        nib(4'h2, 3); nib(4'hA, 3); nib(4'h5, 3); nib(4'h3, 3);
        chk("gap_nostart", 32'(start_cnt - s0), 0);
        nib(4'hC, 0);
        chk("gap_start", 32'(start), 1);
        chk("gap_a", 32'(a), 32'hA5);
        chk("gap_b", 32'(b), 32'h3C);
        chk("gap_op", 32'(op), 2);

        // done_calc during FIRE is ignored
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("fire_done_busy", 32'(busy), 1);
        chk("gap_pulses", 32'(start_cnt - s0), 1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("late_done_busy", 32'(busy), 0);

        // abort mid-load
        s0 = start_cnt;
        nib(4'h1, 0); nib(4'hF, 0); nib(4'hF, 0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_a", 32'(a), 32'hFF);
        nib(4'h0, 0); nib(4'h1, 0); nib(4'h2, 0); nib(4'h3, 0); nib(4'h4, 0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        chk("abort_op", 32'(op), 0);
        chk("abort_a2", 32'(a), 32'h12);
        chk("abort_b2", 32'(b), 32'h34);
        chk("abort_pulses", 32'(start_cnt - s0), 1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);

        // asynchronous reset during LOAD_B
        nib(4'h3, 0); nib(4'hA, 0); nib(4'hB, 0); nib(4'hC, 0);
        #3 reset = 1'b1;
        #1;
        chk("arst_op", 32'(op), 0);
        chk("arst_a", 32'(a), 0);
        chk("arst_b", 32'(b), 0);
        chk("arst_start", 32'(start), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ovr", 32'(overrun), 0);
        @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        s0 = start_cnt;
        nib(4'h1, 0); nib(4'h0, 0); nib(4'h0, 0); nib(4'hF, 0); nib(4'hF, 0);
        chk("arst_seq_op", 32'(op), 1);
        chk("arst_seq_a", 32'(a), 32'h00);
        chk("arst_seq_b", 32'(b), 32'hFF);
        chk("arst_seq_start", 32'(start), 1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 99) < 55), 4'($urandom), 1'($urandom_range(0, 99) < 3),
                1'($urandom_range(0, 99) < 20));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
